max_subtract: RTL and testbench
===============================

// Module: max_subtract
// PURPOSE
//  Consumer of the max-forwarding pipeline output. Per beat, selects the correct max for each lane and
//  outputs x - max, saturated and clamped to <= 0, as the exp-approximation input. Max source per lane:
//  segment bypass max (modes 0-2) or forwarded group max (modes 3-13). Tracks multi-beat group framing.
// PARAMETERS
//  LANES      64   elements per beat
//  DW         16   signed element / max width
//  MAX_BEATS  12   longest group (mode 13)
// PORTS
//  i_clk            in   1          clock
//  i_rst            in   1          sync reset, active-high
//  i_en             in   1          global stall; 0 = every register holds
//  i_valid_max      in   1          beat valid (from forwarder o_valid_max)
//  i_global_max     in   DW         group max, valid for modes 3-13
//  i_length_mode    in   4          0:16-seg 1:32-seg 2:64-seg 3..13: group of (mode-1) beats
//  i_in_flat        in   LANES*DW   lane k = bits [k*DW +: DW], signed
//  i_max64_0        in   DW         mode-2 max, all lanes
//  i_max32_0/1      in   DW         mode-1 max, lanes 0-31 / 32-63
//  i_max16_0..3     in   DW         mode-0 max, lanes 16j..16j+15
//  o_valid          out  1          result valid
//  o_diff_flat      out  LANES*DW   lane k = sat(x_k - max_k), always <= 0
//  o_length_mode    out  4          mode, aligned with o_diff_flat
//  o_group_last     out  1          last beat of group (1 on every valid beat for modes 0-2)
//  o_err_frame      out  1          sticky framing error
//  o_err_max        out  1          sticky: global max changed inside group, or some x > max
// BEHAVIOUR
//  Reset: all outputs 0; o_diff_flat 0; internal beat counter 0; state IDLE.
//  i_en=0 freezes pipeline, counter, FSM and sticky flags. Nothing advances.
//  Latency: 2 enabled cycles.
//   S1: register per-lane max, x, valid, mode and last flag.
//   S2: register diff and outputs.
//  Diff: d = {x[15],x} - {m[15],m} (17b).
//   d > 0      -> 0, set o_err_max
//   d < -32768 -> 16'h8000
//   else       -> d[15:0]
//  Modes 14/15: treated as mode 2 (64-seg). o_err_frame is set.
//  Group FSM (advances only when i_en & i_valid_max):
//   IDLE: valid beat with mode >= 3 -> latch mode and global max; cnt = 1.
//         If cnt == mode-1 (mode 3 needs 2 beats, so never on the first beat), this is last; else -> IN_GRP.
//         Modes 0-2 stay in IDLE with last = 1.
//   IN_GRP: each valid beat does cnt++. Last when cnt+1 == mode-1 -> IDLE, cnt = 0.
//         Mode != latched mode -> set o_err_frame; restart group with the new mode on this beat.
//         Global max != latched max -> set o_err_max; continue the group.
//   IN_GRP with i_en=1 & i_valid_max=0: group aborted -> IDLE, set o_err_frame.
//         Matches the forwarder, which resets its count on an invalid beat.
//  Invalid beats still propagate data; o_valid=0, o_group_last=0.
//  Sticky flags clear only on i_rst. Reset mid-group discards the group with no error.
//  Back-to-back groups need no gap. Last beat -> IDLE, and the next cycle's beat may start a new group.
// STRUCTURE
//  Package max_pkg holds:
//   - LEN_SEG16/32/64 constants
//   - LEN_GRP_MIN = 3, LEN_GRP_MAX = 13
//   - function grp_beats(mode) = mode-1
//   - shared DW/LANES localparams
//   The forwarder side adopts the same package.
//  Sub-module sat_sub (DW-bit saturating x - m, clamp to <= 0, overflow/positive flag).
//   Combinational; instantiated LANES times in S2.
//  Top holds: lane max mux, 2-stage pipeline, group FSM + counter, error flags.
// TESTING
//  1 mode 0: lanes = 0x0100, max16_0..3 = 0x0100, 0x0200, 0x0300, 0x0400
//    -> 2 cycles later lanes 0-15 = 0, 16-31 = 0xFF00, 32-47 = 0xFE00, 48-63 = 0xFD00; last = 1.
//  2 mode 4 (3 beats), global max 0x1000 on all beats, x = 0x0F00
//    -> diff 0xFF00, o_group_last only on beat 3, no errors.
//  3 saturation: x = 0x8000, max = 0x7FFF -> 0x8000.
//    x = 0x0010 > max = 0x0001 -> diff 0, o_err_max = 1.
//  4 mode 5 group, i_valid_max low after beat 2 -> o_err_frame = 1.
//    Following mode 3 group completes normally with last on its 2nd beat.
//  5 i_en = 0 for 3 cycles mid-group -> outputs and counter frozen.
//    Resume gives the same results as an unstalled run. Mode change mid-group -> o_err_frame.
//  6 i_rst asserted at beat 2 of mode 13 -> all outputs 0 next cycle.
//    Fresh mode 13 group then yields last on beat 12, no errors.

Source files
------------

// File: rtl/max_pkg.sv
// max_pkg: shared widths, length-mode encodings and group helpers for the max-forwarding path
package max_pkg;
  localparam int LANES = 64;
  localparam int DW = 16;
  localparam int MAX_BEATS = 12;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [3:0] LEN_SEG16 = 4'd0;
  localparam logic [3:0] LEN_SEG32 = 4'd1;
  localparam logic [3:0] LEN_SEG64 = 4'd2;
  localparam logic [3:0] LEN_GRP_MIN = 4'd3;
  localparam logic [3:0] LEN_GRP_MAX = 4'd13;
  typedef enum logic {IDLE, IN_GRP} grp_state_t;
  function automatic logic [CW-1:0] grp_beats(input logic [3:0] mode);
    return CW'(mode - 4'd1);
  endfunction
endpackage

// File: rtl/max_subtract_sat_sub.sv
// sat_sub: saturating x - m clamped to <= 0, flags a positive difference
module sat_sub
  import max_pkg::*;
(
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] m,
  output logic [DW-1:0] d,
  output logic          pos
);
  logic [DW:0] s;
  assign s = {x[DW-1], x} - {m[DW-1], m};
  assign pos = !s[DW] && |s[DW-1:0];
  assign d = pos ? '0 : (s[DW] && !s[DW-1]) ? {1'b1, {(DW-1){1'b0}}} : s[DW-1:0];
endmodule

// File: rtl/max_subtract.sv
// max_subtract: per-lane max select, 2-stage saturating x - max, group framing and sticky error flags
module max_subtract
  import max_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_valid_max,
  input  logic [DW-1:0]       i_global_max,
  input  logic [3:0]          i_length_mode,
  input  logic [LANES*DW-1:0] i_in_flat,
  input  logic [DW-1:0]       i_max64_0,
  input  logic [DW-1:0]       i_max32_0,
  input  logic [DW-1:0]       i_max32_1,
  input  logic [DW-1:0]       i_max16_0,
  input  logic [DW-1:0]       i_max16_1,
  input  logic [DW-1:0]       i_max16_2,
  input  logic [DW-1:0]       i_max16_3,
  output logic                o_valid,
  output logic [LANES*DW-1:0] o_diff_flat,
  output logic [3:0]          o_length_mode,
  output logic                o_group_last,
  output logic                o_err_frame,
  output logic                o_err_max
);
  grp_state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [3:0] lmode, nmode, mode_eff, s1_mode;
  logic [DW-1:0] lmax, nmax;
  logic last, ferr, merr, is_grp;
  logic s1_valid, s1_last, s1_ferr, s1_merr;
  logic [3:0][DW-1:0] m16;
  logic [1:0][DW-1:0] m32;
  logic [LANES*DW-1:0] lane_max, s1_x, s1_m, diff;
  logic [LANES-1:0] pos;
  assign m16 = {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
  assign m32 = {i_max32_1, i_max32_0};
  // out-of-range modes fall back to a single 64-lane segment
  assign mode_eff = i_length_mode > LEN_GRP_MAX ? LEN_SEG64 : i_length_mode;
  assign is_grp = mode_eff >= LEN_GRP_MIN;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_max[k*DW +: DW] = mode_eff == LEN_SEG16 ? m16[k/16] :
                                  mode_eff == LEN_SEG32 ? m32[k/32] :
                                  mode_eff == LEN_SEG64 ? i_max64_0 : i_global_max;
    sat_sub u_sub (
      .x   (s1_x[k*DW +: DW]),
      .m   (s1_m[k*DW +: DW]),
      .d   (diff[k*DW +: DW]),
      .pos (pos[k])
    );
  end
  always_comb begin
    nstate = state;
    ncnt = cnt;
    nmode = lmode;
    nmax = lmax;
    last = 1'b0;
    ferr = 1'b0;
    merr = 1'b0;
    if (i_valid_max) begin
      ferr = i_length_mode > LEN_GRP_MAX;
      if (state == IN_GRP && i_length_mode == lmode) begin
        merr = i_global_max != lmax;
        last = cnt + 1'b1 == grp_beats(lmode);
        nstate = last ? IDLE : IN_GRP;
        ncnt = last ? '0 : cnt + 1'b1;
      end else begin
        // a mode change inside a group restarts framing on this beat
        ferr = ferr | (state == IN_GRP);
        nmode = i_length_mode;
        nmax = i_global_max;
        last = !is_grp;
        nstate = is_grp ? IN_GRP : IDLE;
        ncnt = is_grp ? CW'(1) : '0;
      end
    end else if (state == IN_GRP) begin
      ferr = 1'b1;
      nstate = IDLE;
      ncnt = '0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      lmode <= '0;
      lmax <= '0;
      s1_x <= '0;
      s1_m <= '0;
      s1_valid <= 1'b0;
      s1_mode <= '0;
      s1_last <= 1'b0;
      s1_ferr <= 1'b0;
      s1_merr <= 1'b0;
      o_valid <= 1'b0;
      o_diff_flat <= '0;
      o_length_mode <= '0;
      o_group_last <= 1'b0;
      o_err_frame <= 1'b0;
      o_err_max <= 1'b0;
    end else if (i_en) begin
      state <= nstate;
      cnt <= ncnt;
      lmode <= nmode;
      lmax <= nmax;
      s1_x <= i_in_flat;
      s1_m <= lane_max;
      s1_valid <= i_valid_max;
      s1_mode <= i_length_mode;
      s1_last <= last;
      s1_ferr <= ferr;
      s1_merr <= merr;
      o_valid <= s1_valid;
      o_diff_flat <= diff;
      o_length_mode <= s1_mode;
      o_group_last <= s1_last;
      o_err_frame <= o_err_frame | s1_ferr;
      o_err_max <= o_err_max | s1_merr | (s1_valid & |pos);
    end
  end
endmodule

// File: tb/tb_max_subtract.sv
// tb_max_subtract: directed and randomized checks of max_subtract against a behavioural model
module tb_max_subtract;
  localparam int L = 64;
  localparam int W = 16;
  logic i_clk = 0, i_rst = 1, i_en = 1, i_valid_max = 0;
  logic [W-1:0] i_global_max = '0;
  logic [3:0] i_length_mode = '0;
  logic [L*W-1:0] i_in_flat = '0;
  logic [W-1:0] i_max64_0 = '0, i_max32_0 = '0, i_max32_1 = '0;
  logic [W-1:0] i_max16_0 = '0, i_max16_1 = '0, i_max16_2 = '0, i_max16_3 = '0;
  logic o_valid, o_group_last, o_err_frame, o_err_max;
  logic [L*W-1:0] o_diff_flat;
  logic [3:0] o_length_mode;
  int tests = 0, fails = 0;
  logic p_valid, p_last, p_ferr, p_merr, e_valid, e_last, e_ferr, e_merr;
  logic [3:0] p_mode, e_mode;
  logic [L*W-1:0] p_diff, e_diff;
  bit g_active;
  int g_mode, g_seen, eff;
  logic [W-1:0] g_max;

  always #5 i_clk = ~i_clk;

  max_subtract dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid_max(i_valid_max),
    .i_global_max(i_global_max), .i_length_mode(i_length_mode), .i_in_flat(i_in_flat),
    .i_max64_0(i_max64_0), .i_max32_0(i_max32_0), .i_max32_1(i_max32_1),
    .i_max16_0(i_max16_0), .i_max16_1(i_max16_1), .i_max16_2(i_max16_2), .i_max16_3(i_max16_3),
    .o_valid(o_valid), .o_diff_flat(o_diff_flat), .o_length_mode(o_length_mode),
    .o_group_last(o_group_last), .o_err_frame(o_err_frame), .o_err_max(o_err_max)
  );

  task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: each accepted beat becomes a result that appears two enabled edges later
  always @(posedge i_clk) begin
    if (i_rst) begin
      {p_valid, p_last, p_ferr, p_merr, e_valid, e_last, e_ferr, e_merr} = '0;
      p_mode = '0; e_mode = '0; p_diff = '0; e_diff = '0;
      g_active = 0; g_seen = 0; g_mode = 0; g_max = '0;
    end else if (i_en) begin
      e_valid = p_valid; e_last = p_last; e_mode = p_mode; e_diff = p_diff;
      e_ferr = e_ferr | p_ferr; e_merr = e_merr | p_merr;
      eff = i_length_mode > 13 ? 2 : int'(i_length_mode);
      p_valid = i_valid_max; p_mode = i_length_mode; p_last = 0; p_ferr = 0; p_merr = 0;
      for (int k = 0; k < L; k++) begin
        logic [W-1:0] mm;
        int xv, mv, d;
        case (eff)
          0: mm = k < 16 ? i_max16_0 : k < 32 ? i_max16_1 : k < 48 ? i_max16_2 : i_max16_3;
          1: mm = k < 32 ? i_max32_0 : i_max32_1;
          2: mm = i_max64_0;
          default: mm = i_global_max;
        endcase
        xv = $signed(i_in_flat[k*W +: W]);
        mv = $signed(mm);
        d = xv - mv;
        if (d > 0) begin
          d = 0;
          if (i_valid_max) p_merr = 1;
        end else if (d < -32768) d = -32768;
        p_diff[k*W +: W] = d[15:0];
      end
      if (i_valid_max) begin
        if (i_length_mode > 13) p_ferr = 1;
        if (g_active && int'(i_length_mode) == g_mode) begin
          if (i_global_max != g_max) p_merr = 1;
          g_seen++;
          p_last = g_seen == g_mode - 1;
          if (p_last) g_active = 0;
        end else begin
          if (g_active) p_ferr = 1;
          if (eff >= 3) begin
            g_active = 1; g_mode = eff; g_max = i_global_max; g_seen = 1;
          end else begin
            g_active = 0; p_last = 1;
          end
        end
      end else if (g_active) begin
        p_ferr = 1; g_active = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    chk("valid", o_valid, e_valid);
    chk("diff", o_diff_flat, e_diff);
    chk("mode", o_length_mode, e_mode);
    chk("last", o_group_last, e_last);
    chk("err_frame", o_err_frame, e_ferr);
    chk("err_max", o_err_max, e_merr);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [3:0] md, input logic [W-1:0] gm);
    i_valid_max = v; i_length_mode = md; i_global_max = gm;
    step();
  endtask

  task automatic fill(input logic [W-1:0] x);
    for (int k = 0; k < L; k++) i_in_flat[k*W +: W] = x;
  endtask

  task automatic rnd_lanes(input bit neg);
    logic [W-1:0] mk;
    mk = neg ? 16'h7FFF : 16'hFFFF;
    for (int k = 0; k < L; k++) i_in_flat[k*W +: W] = neg ? (16'h8000 | W'($urandom)) : W'($urandom);
    i_max64_0 = W'($urandom) & mk; i_max32_0 = W'($urandom) & mk; i_max32_1 = W'($urandom) & mk;
    i_max16_0 = W'($urandom) & mk; i_max16_1 = W'($urandom) & mk;
    i_max16_2 = W'($urandom) & mk; i_max16_3 = W'($urandom) & mk;
  endtask

  task automatic do_reset();
    i_rst = 1;
    step();
    i_rst = 0;
  endtask

  initial begin
    logic [W-1:0] gm;
    int cur, rem;
    bit v;
    step(); step();
    i_rst = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_diff", o_diff_flat, 0);
    fill(16'h0100);
    i_max16_0 = 16'h0100; i_max16_1 = 16'h0200; i_max16_2 = 16'h0300; i_max16_3 = 16'h0400;
    beat(1, 0, 0); beat(0, 0, 0);
    chk("t1_lane0", o_diff_flat[0 +: W], 16'h0000);
    chk("t1_lane16", o_diff_flat[16*W +: W], 16'hFF00);
    chk("t1_lane32", o_diff_flat[32*W +: W], 16'hFE00);
    chk("t1_lane48", o_diff_flat[48*W +: W], 16'hFD00);
    chk("t1_last", o_group_last, 1);
    fill(16'h0F00);
    repeat (3) beat(1, 4, 16'h1000);
    chk("t2_last_b2", o_group_last, 0);
    beat(0, 4, 16'h1000);
    chk("t2_diff", o_diff_flat[7*W +: W], 16'hFF00);
    chk("t2_last_b3", o_group_last, 1);
    chk("t2_frame", o_err_frame, 0);
    chk("t2_maxerr", o_err_max, 0);
    do_reset();
    i_max64_0 = 16'h7FFF; fill(16'h8000);
    beat(1, 2, 0);
    i_max64_0 = 16'h0001; fill(16'h0010);
    beat(1, 2, 0);
    chk("t3_sat", o_diff_flat[3*W +: W], 16'h8000);
    chk("t3_maxerr0", o_err_max, 0);
    beat(0, 2, 0);
    chk("t3_clamp", o_diff_flat[3*W +: W], 16'h0000);
    chk("t3_maxerr1", o_err_max, 1);
    do_reset();
    fill(16'h0100);
    beat(1, 5, 16'h0200); beat(1, 5, 16'h0200); beat(0, 5, 16'h0200);
    beat(1, 3, 16'h0200); beat(1, 3, 16'h0200);
    chk("t4_frame", o_err_frame, 1);
    chk("t4_last_a", o_group_last, 0);
    beat(0, 3, 16'h0200);
    chk("t4_last_b", o_group_last, 1);
    do_reset();
    fill(16'h0700);
    beat(1, 6, 16'h0800); beat(1, 6, 16'h0800);
    i_en = 0;
    repeat (3) begin
      rnd_lanes(0);
      i_valid_max = 0; i_length_mode = 4'($urandom); i_global_max = W'($urandom);
      step();
    end
    i_en = 1;
    fill(16'h0700);
    repeat (3) beat(1, 6, 16'h0800);
    beat(0, 6, 16'h0800);
    chk("t5_last", o_group_last, 1);
    chk("t5_diff", o_diff_flat[0 +: W], 16'hFF00);
    chk("t5_frame0", o_err_frame, 0);
    beat(1, 4, 16'h0800); beat(1, 7, 16'h0800); beat(1, 7, 16'h0800);
    chk("t5_frame1", o_err_frame, 1);
    repeat (4) beat(1, 7, 16'h0800);
    beat(0, 0, 0);
    do_reset();
    fill(16'h0100);
    beat(1, 13, 16'h0100);
    i_rst = 1;
    beat(1, 13, 16'h0100);
    i_rst = 0;
    chk("t6_valid", o_valid, 0);
    chk("t6_diff", o_diff_flat, 0);
    chk("t6_last", o_group_last, 0);
    repeat (12) beat(1, 13, 16'h0100);
    chk("t6_last_b11", o_group_last, 0);
    beat(0, 13, 16'h0100);
    chk("t6_last_b12", o_group_last, 1);
    chk("t6_frame", o_err_frame, 0);
    chk("t6_maxerr", o_err_max, 0);
    do_reset();
    cur = 0; rem = 0; gm = '0;
    repeat (3000) begin
      rnd_lanes($urandom_range(0, 1) == 1);
      if (rem == 0 || $urandom_range(0, 39) == 0) begin
        cur = $urandom_range(0, 15);
        rem = (cur >= 3 && cur <= 13) ? cur - 1 : 1;
        gm = W'($urandom);
      end
      if ($urandom_range(0, 29) == 0) gm = W'($urandom);
      i_en = $urandom_range(0, 9) != 0;
      i_rst = $urandom_range(0, 99) == 0;
      v = $urandom_range(0, 11) != 0;
      i_valid_max = v; i_length_mode = 4'(cur); i_global_max = gm;
      step();
      if (v && i_en && !i_rst && rem > 0) rem--;
    end
    i_rst = 0; i_en = 1;
    beat(0, 0, 0); beat(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
